motor_ramp: RTL
===============

Name: motor_ramp

Overview:
- Command-shaping stage directly upstream of each H-bridge motor_controller.
- Accepts a sign-magnitude speed command and slews it toward the target at a programmable rate, producing the dir, on and duty_cycle inputs of the motor_controller.
- Forces a zero-speed dwell before any direction reversal.
- A command watchdog ramps the motor to stop if the host goes silent.

Parameters:
- RAMP_DIV, 5000: clk cycles per ramp tick (minimum 2).
- DWELL_TICKS, 100: ramp ticks held at zero magnitude before a direction flip (minimum 1).
- WATCHDOG_CYCLES, 25000000: clk cycles without cmd_valid before the target is forced to zero.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  one-cycle strobe; latches cmd_dir/cmd_mag
- cmd_dir  in  1  requested direction
- cmd_mag  in  16  requested duty magnitude (counts)
- step  in  16  maximum magnitude change per ramp tick; 0 freezes ramping
- period  in  16  PWM period, same value fed to motor_controller
- dir  out  1  to motor_controller dir
- on  out  1  to motor_controller on
- duty_cycle  out  16  to motor_controller duty_cycle
- at_target  out  1  cur_dir/cur_mag equal the effective target
- timeout  out  1  watchdog has fired; sticky until next cmd_valid

Behaviour:
- Reset (asynchronous, active-low): all outputs 0, tgt_dir=0, tgt_mag=0, cur_dir=0, cur_mag=0, state=IDLE, all counters 0.
- Target latch:
  - On cmd_valid: tgt_dir<=cmd_dir and tgt_mag<=min(cmd_mag, period).
  - Clear timeout and the watchdog counter.
  - Last write wins; commands are accepted in every state.
- Effective target: tgt_mag_eff = min(tgt_mag, period), re-evaluated every cycle.
- Ramp tick:
  - Prescaler counts 0..RAMP_DIV-1; tick asserts for one cycle at the wrap.
  - Free-running from reset; not restarted by commands.
- States:
  - IDLE: cur_mag==0. Leave on a tick when tgt_mag_eff!=0.
    - If tgt_dir==cur_dir, go to RAMP.
    - Otherwise go to DWELL with dwell counter = 0.
  - RAMP, same direction, on each tick: cur_mag moves toward tgt_mag_eff by step, saturating exactly at the target (no overshoot, no 16-bit wrap; compute in 17 bits).
  - RAMP, tgt_dir!=cur_dir, on each tick: cur_mag decreases by step, saturating at 0.
  - Reaching cur_mag==0 in RAMP:
    - Go to DWELL if tgt_dir!=cur_dir and tgt_mag_eff!=0.
    - Otherwise go to IDLE.
  - DWELL:
    - cur_mag held at 0; dwell counter increments per tick.
    - When it reaches DWELL_TICKS: cur_dir<=tgt_dir, then go to RAMP if tgt_mag_eff!=0, else IDLE.
    - If the target returns to cur_dir during dwell, the dwell still completes (no shortcut).
- Period clamp:
  - If period drops below cur_mag, cur_mag<=period on the next clk edge.
  - This happens regardless of tick or state; it is the only non-ramped change.
- Outputs:
  - Registered from state: dir=cur_dir, duty_cycle=cur_mag, on=(cur_mag!=0).
  - Output latency is one clk after a cur_* update.
  - dir changes only while on==0, so motor_controller dead-time sees a single transition.
- at_target = (cur_mag==tgt_mag_eff) && (cur_dir==tgt_dir || tgt_mag_eff==0). Registered.
- Watchdog:
  - Counter increments every clk; it saturates and does not wrap.
  - When it reaches WATCHDOG_CYCLES: tgt_mag<=0 (tgt_dir unchanged) and timeout<=1.
  - The normal ramp then stops the motor.
- Simultaneous events:
  - cmd_valid in the same cycle as watchdog expiry: the command wins and timeout stays 0.
  - cmd_valid in the same cycle as a tick: the tick uses the newly latched target.
- step==0: cur_mag holds; a pending direction reversal stalls in RAMP (documented, not an error).

Decomposition:
- Shared package/defines: state encodings (IDLE, RAMP, DWELL) and the widths MAG_W=16 and WDOG_W=25, alongside the existing PERIOD_LENGTH / DEAD_TIME defines.
- Sub-module ramp_tick_gen: parameterised prescaler producing the one-cycle tick, reusable by the other thruster channels.

Test Plan:
- Bench settings: RAMP_DIV=4, DWELL_TICKS=2, WATCHDOG_CYCLES=200, period=1000.
- Reset mid-ramp: assert reset_n=0 while duty_cycle=30 -> dir, on, duty_cycle and timeout are 0 immediately (asynchronous); after release, duty_cycle stays 0 until the next cmd_valid.
- Forward ramp: step=10, cmd dir=0 mag=35 -> duty_cycle steps 10, 20, 30, 35 on successive ticks, 4 clk apart. on rises with the first step. at_target=1 one clk after 35.
- Reversal: from dir=0 mag=35, cmd dir=1 mag=20 ->
  - duty_cycle goes 25, 15, 5, 0.
  - Two ticks of dwell follow with on=0.
  - dir flips to 1 while on=0, then duty_cycle goes 10, 20.
  - dir never changes while on=1.
- Period clamp: duty_cycle=500, drive period=300 -> duty_cycle=300 on the next clk without waiting for a tick. A cmd of mag=900 then saturates at 300.
- Watchdog: no cmd_valid for 200 clk at mag=40, step=10 -> timeout=1 and the ramp runs 30, 20, 10, 0. A new cmd_valid clears timeout in the same cycle. A cmd_valid in the exact expiry cycle leaves timeout=0.
- Saturation edge: step=0xFFFF, cmd mag=0xFFFF with period=0xFFFF -> a single tick reaches 0xFFFF with no wrap to a small value; then cmd mag=0 -> the next tick gives 0.

Source files
------------

// File: rtl/motor_ramp_pkg.sv
// Shared types and widths for the motor command-shaping path.
// Ramp state encoding, datapath widths and a magnitude min helper.
package motor_ramp_pkg;

    localparam int MAG_W  = 16;
    localparam int WDOG_W = 25;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        DWELL = 2'd2
    } ramp_state_t;

    function automatic logic [MAG_W-1:0] min_mag(input logic [MAG_W-1:0] a,
                                                 input logic [MAG_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/ramp_tick_gen.sv
// Free-running prescaler: counts 0..DIV-1 and asserts o_tick for the
// single cycle in which the count wraps. Shared by all thruster channels.
module ramp_tick_gen #(
    parameter int DIV = 5000
) (
    input  logic clk,
    input  logic reset_n,
    output logic o_tick
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(DIV - 1));
    assign o_tick = w_wrap;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    r_cnt <= '0;
        else if (w_wrap) r_cnt <= '0;
        else             r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/motor_ramp.sv
// Slews a sign-magnitude speed command toward its target at a fixed rate,
// with a zero-speed dwell before reversal and a host-silence watchdog.
module motor_ramp
    import motor_ramp_pkg::*;
#(
    parameter int RAMP_DIV        = 5000,
    parameter int DWELL_TICKS     = 100,
    parameter int WATCHDOG_CYCLES = 25000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    input  logic             cmd_dir,
    input  logic [MAG_W-1:0] cmd_mag,
    input  logic [MAG_W-1:0] step,
    input  logic [MAG_W-1:0] period,
    output logic             dir,
    output logic             on,
    output logic [MAG_W-1:0] duty_cycle,
    output logic             at_target,
    output logic             timeout
);

    localparam int DW_W = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;

    ramp_state_t      r_state, w_state_nxt;
    logic             r_tgt_dir, r_cur_dir, w_cur_dir_nxt, w_tgt_dir;
    logic [MAG_W-1:0] r_tgt_mag, r_cur_mag, w_cur_mag_nxt, w_mag_pre;
    logic [MAG_W-1:0] w_tgt_mag, w_tgt_eff, w_tgt_eff_q, w_ramp_mag;
    logic [MAG_W:0]   w_sum;
    logic [DW_W-1:0]  r_dwell_cnt, w_dwell_nxt;
    logic [WDOG_W-1:0] r_wdog;
    logic             w_wdog_expire, w_tick;
    logic             r_dir, r_on, r_at_target, r_timeout;
    logic [MAG_W-1:0] r_duty;

    ramp_tick_gen #(.DIV(RAMP_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .o_tick  (w_tick)
    );

    // Target as it stands after this edge, so a command or expiry landing
    // on a tick is already seen by that tick.
    assign w_wdog_expire = (r_wdog == WDOG_W'(WATCHDOG_CYCLES - 1));
    assign w_tgt_dir     = cmd_valid ? cmd_dir : r_tgt_dir;
    assign w_tgt_mag     = cmd_valid     ? min_mag(cmd_mag, period) :
                           w_wdog_expire ? '0 : r_tgt_mag;
    assign w_tgt_eff     = min_mag(w_tgt_mag, period);
    assign w_tgt_eff_q   = min_mag(r_tgt_mag, period);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tgt_dir <= 1'b0;
            r_tgt_mag <= '0;
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_tgt_dir <= w_tgt_dir;
            r_tgt_mag <= w_tgt_mag;
            if (cmd_valid) begin
                r_wdog    <= '0;
                r_timeout <= 1'b0;
            end else if (r_wdog != WDOG_W'(WATCHDOG_CYCLES)) begin
                r_wdog <= r_wdog + 1'b1;
                if (w_wdog_expire) r_timeout <= 1'b1;
            end
        end
    end

    // One ramp step in 17 bits so a full-scale step cannot wrap.
    always_comb begin
        w_sum = {1'b0, r_cur_mag} + {1'b0, step};
        if (r_cur_dir != w_tgt_dir)
            w_ramp_mag = (r_cur_mag > step) ? r_cur_mag - step : '0;
        else if (r_cur_mag < w_tgt_eff)
            w_ramp_mag = (w_sum > {1'b0, w_tgt_eff}) ? w_tgt_eff : w_sum[MAG_W-1:0];
        else
            w_ramp_mag = ((r_cur_mag - w_tgt_eff) > step) ? r_cur_mag - step : w_tgt_eff;
    end

    // NOTE: every always_comb output gets a default first, so no latches.
    always_comb begin
        w_state_nxt   = r_state;
        w_cur_dir_nxt = r_cur_dir;
        w_dwell_nxt   = r_dwell_cnt;
        w_mag_pre     = r_cur_mag;
        if (w_tick) begin
            unique case (r_state)
                IDLE: begin
                    if (w_tgt_eff != '0) begin
                        w_dwell_nxt = '0;
                        w_state_nxt = (w_tgt_dir == r_cur_dir) ? RAMP : DWELL;
                    end
                end
                RAMP: begin
                    w_mag_pre   = w_ramp_mag;
                    w_dwell_nxt = '0;
                    if (w_ramp_mag == '0)
                        w_state_nxt = (w_tgt_dir != r_cur_dir && w_tgt_eff != '0) ? DWELL : IDLE;
                end
                DWELL: begin
                    if (r_dwell_cnt == DW_W'(DWELL_TICKS - 1)) begin
                        w_cur_dir_nxt = w_tgt_dir;
                        w_dwell_nxt   = '0;
                        w_state_nxt   = (w_tgt_eff != '0) ? RAMP : IDLE;
                    end else begin
                        w_dwell_nxt = r_dwell_cnt + 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
        w_cur_mag_nxt = min_mag(w_mag_pre, period);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cur_dir   <= 1'b0;
            r_cur_mag   <= '0;
            r_dwell_cnt <= '0;
            r_dir       <= 1'b0;
            r_on        <= 1'b0;
            r_duty      <= '0;
            r_at_target <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur_dir   <= w_cur_dir_nxt;
            r_cur_mag   <= w_cur_mag_nxt;
            r_dwell_cnt <= w_dwell_nxt;
            r_dir       <= r_cur_dir;
            r_on        <= (r_cur_mag != '0);
            r_duty      <= r_cur_mag;
            r_at_target <= (r_cur_mag == w_tgt_eff_q) &&
                           (r_cur_dir == r_tgt_dir || w_tgt_eff_q == '0);
        end
    end

    assign dir        = r_dir;
    assign on         = r_on;
    assign duty_cycle = r_duty;
    assign at_target  = r_at_target;
    assign timeout    = r_timeout;

endmodule
